local_scheduler: RTL

- Shares the single service crew between the car-wash lane and the workshop (taller) lane.
- Queues debounced customer requests per lane and grants exactly one lane at a time, round-robin.
- Its en_c/en_t outputs drive the EN inputs of the car-wash and workshop FSMs; their completion flags return as done_c/done_t.
- A watchdog frees the crew if a served lane never reports completion.

---
 rtl/local_scheduler_pkg.sv | 15 +
 rtl/local_scheduler_pend_counter.sv | 30 +++
 rtl/local_scheduler.sv | 107 ++++++++++
 3 files changed

// File: rtl/local_scheduler_pkg.sv
// Shared constants for the crew scheduler: FSM states, lane ids and
// the default watchdog limit.
package local_scheduler_pkg;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] SERVE_C = 2'b01;
  localparam logic [1:0] SERVE_T = 2'b10;
  localparam logic [1:0] GAP     = 2'b11;

  localparam logic LANE_C = 1'b0;
  localparam logic LANE_T = 1'b1;

  localparam int TIMEOUT_DEF = 200;

endpackage

// File: rtl/local_scheduler_pend_counter.sv
// Saturating pending-request counter; inc and dec together cancel,
// and a request arriving at the ceiling is dropped.
module pend_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && !(&cnt_q))
      cnt_d = cnt_q + W'(1);
    else if (dec && !inc && (|cnt_q))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/local_scheduler.sv
// Round-robin crew scheduler between the car-wash and workshop lanes,
// with a watchdog that frees the crew from a lane that never finishes.
module local_scheduler
  import local_scheduler_pkg::*;
#(
  parameter int CNT_W   = 3,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_c,
  input  logic             req_t,
  input  logic             done_c,
  input  logic             done_t,
  output logic             en_c,
  output logic             en_t,
  output logic [CNT_W-1:0] pend_c,
  output logic [CNT_W-1:0] pend_t,
  output logic             busy,
  output logic             timeout,
  output logic [1:0]       state
);

  logic [1:0]      state_q, state_d;
  logic            last_q, last_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;
  logic            grant_c, grant_t;
  logic            expire;

  assign expire = (wd_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((|pend_c) && (|pend_t))
          state_d = (last_q == LANE_T) ? SERVE_C : SERVE_T;
        else if (|pend_c)
          state_d = SERVE_C;
        else if (|pend_t)
          state_d = SERVE_T;
      end
      SERVE_C: begin
        if (done_c || expire) state_d = GAP;
        to_d = expire && !done_c;
      end
      SERVE_T: begin
        if (done_t || expire) state_d = GAP;
        to_d = expire && !done_t;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign grant_c = (state_q == IDLE) && (state_d == SERVE_C);
  assign grant_t = (state_q == IDLE) && (state_d == SERVE_T);

  always_comb begin
    last_d = last_q;
    if (grant_c) last_d = LANE_C;
    if (grant_t) last_d = LANE_T;
  end

  // Watchdog sits at 0 outside service, so each entry starts from zero.
  assign wd_d = (en_c || en_t) ? wd_q + TO_W'(1) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= LANE_T;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  pend_counter #(.W(CNT_W)) u_pend_c (
    .clk   (clk),
    .reset (reset),
    .inc   (req_c),
    .dec   (grant_c),
    .count (pend_c)
  );

  pend_counter #(.W(CNT_W)) u_pend_t (
    .clk   (clk),
    .reset (reset),
    .inc   (req_t),
    .dec   (grant_t),
    .count (pend_t)
  );

  assign en_c    = (state_q == SERVE_C);
  assign en_t    = (state_q == SERVE_T);
  assign busy    = en_c || en_t;
  assign timeout = to_q;
  assign state   = state_q;

endmodule
